// File: rtl/gpu_scanout_pkg.sv
// Shared types and widths for the SRAM scanout reader.
// WIDTH_BITS / HEIGHT_BITS / CHANNEL_BITS may be overridden on the command line.
// Optional feature macro used by the top: SCANOUT_UNDERFLOW_CNT_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 9
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 8
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

package gpu_scanout_pkg;

  localparam int WIDTH_BITS   = `WIDTH_BITS;
  localparam int HEIGHT_BITS  = `HEIGHT_BITS;
  localparam int CHANNEL_BITS = `CHANNEL_BITS;
  localparam int PIXEL_BITS   = 3 * CHANNEL_BITS;
  // Address is {buffer, y, x}.
  localparam int ADDR_BITS    = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int UNDERFLOW_BITS = 16;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } scan_state_e;

  // One FIFO slot: the pixel plus the position flags that qualify it downstream.
  typedef struct packed {
    pixel_t pixel;
    logic   line_end;
    logic   frame_end;
  } fifo_entry_t;

endpackage

// File: rtl/sram_scanout_reader_fifo.sv
// Synchronous show-ahead FIFO holding scanout pixels between the SRAM and
// the display. Depth must be a power of two (pointers wrap naturally).
module scanout_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0],
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  entry_t           i_push_data,
  input  logic             i_pop,
  output entry_t           o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // A pop on empty is ignored; a push on full is accepted only alongside a pop.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage write.
  // NOTE: the data array has no reset; occupancy is tracked by r_count, so
  // stale contents are never observable and the RAM maps to plain storage.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_scanout_reader.sv
// Frame scanout reader: streams one buffer of an asynchronous SRAM, pixel by
// pixel, into a small FIFO feeding a ready/valid display interface.
// Optional macro SCANOUT_UNDERFLOW_CNT_EN adds underflow_cnt_o.
module sram_scanout_reader
  import gpu_scanout_pkg::*;
#(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  enable_i,
  input  logic                  draw_buffer_i,
  input  logic [PIXEL_BITS-1:0] sram_rdata_i,
  output logic [ADDR_BITS-1:0]  addr_o,
  output logic                  CE0_o,
  output logic                  OE_o,
  output logic                  R_W_o,
  output logic                  CE1_o,
  output logic                  LB_o,
  output logic                  UB_o,
  output logic                  ZZ_o,
  output logic                  SEM_o,
  output logic [PIXEL_BITS-1:0] pixel_o,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic                  line_end_o,
  output logic                  frame_end_o,
  output logic                  frame_done_o
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  ,
  output logic [UNDERFLOW_BITS-1:0] underflow_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  scan_state_e             r_state;
  scan_state_e             w_next_state;
  logic [WIDTH_BITS-1:0]   r_x;
  logic [HEIGHT_BITS-1:0]  r_y;
  logic                    r_read_buf;
  logic                    r_inflight;
  logic                    r_inflight_le;
  logic                    r_inflight_fe;
  logic                    r_fe_sent;

  logic                    w_strobe;
  logic                    w_done;
  logic                    w_room;
  logic                    w_x_last;
  logic                    w_y_last;
  logic [CNT_W:0]          w_occupancy;

  fifo_entry_t             w_push_data;
  fifo_entry_t             w_head;
  logic [CNT_W-1:0]        w_count;
  logic                    w_empty;
  logic                    w_valid;
  logic                    w_pop;

  assign w_x_last = (r_x == WIDTH_BITS'(FRAME_W - 1));
  assign w_y_last = (r_y == HEIGHT_BITS'(FRAME_H - 1));

  // Slots already queued plus the one read still on the SRAM bus; a strobe is
  // only allowed when its data is guaranteed a free slot on arrival.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_room      = (w_occupancy < DEPTH_V);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic, read strobe and end-of-frame detection.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_strobe     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) w_next_state = ST_LATCH;
      end
      ST_LATCH: begin
        w_next_state = ST_READ;
      end
      ST_READ: begin
        if (w_room) begin
          w_strobe = 1'b1;
          if (w_x_last && w_y_last) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_fe_sent && w_empty && !r_inflight) begin
          w_done       = 1'b1;
          w_next_state = enable_i ? ST_LATCH : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Raster position of the next read; wraps x into y, and both to 0 at frame end.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == ST_LATCH) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_strobe) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + HEIGHT_BITS'(1);
      end else begin
        r_x <= r_x + WIDTH_BITS'(1);
      end
    end
  end

  // Display buffer is chosen once per frame: the one the GPU is not drawing.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     r_read_buf <= 1'b0;
    else if (r_state == ST_LATCH)   r_read_buf <= ~draw_buffer_i;
  end

  // Track the outstanding read and the position flags that go with its data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_inflight    <= 1'b0;
      r_inflight_le <= 1'b0;
      r_inflight_fe <= 1'b0;
    end else begin
      r_inflight    <= w_strobe;
      r_inflight_le <= w_strobe & w_x_last;
      r_inflight_fe <= w_strobe & w_x_last & w_y_last;
    end
  end

  // Remember that the frame's last pixel has left, so DRAIN knows it may finish.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                        r_fe_sent <= 1'b0;
    else if (r_state == ST_LATCH)      r_fe_sent <= 1'b0;
    else if (w_pop && w_head.frame_end) r_fe_sent <= 1'b1;
  end

  assign w_push_data.pixel     = sram_rdata_i;
  assign w_push_data.line_end  = r_inflight_le;
  assign w_push_data.frame_end = r_inflight_fe;

  scanout_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & pixel_ready_i;

`ifdef SCANOUT_UNDERFLOW_CNT_EN
  logic [UNDERFLOW_BITS-1:0] r_underflow_cnt;

  // Saturating count of cycles the display wanted a pixel we did not have.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_underflow_cnt <= '0;
    end else if (r_state == ST_LATCH) begin
      r_underflow_cnt <= '0;
    end else if ((r_state == ST_READ || r_state == ST_DRAIN) &&
                 pixel_ready_i && !w_valid && !(&r_underflow_cnt)) begin
      r_underflow_cnt <= r_underflow_cnt + UNDERFLOW_BITS'(1);
    end
  end

  assign underflow_cnt_o = r_underflow_cnt;
`endif

  // SRAM control: chip and output enable fall together only on a strobe cycle.
  assign addr_o = {r_read_buf, r_y, r_x};
  assign CE0_o  = ~w_strobe;
  assign OE_o   = ~w_strobe;
  assign R_W_o  = 1'b1;
  assign CE1_o  = 1'b1;
  assign LB_o   = 1'b0;
  assign UB_o   = 1'b0;
  assign ZZ_o   = 1'b1;
  assign SEM_o  = 1'b1;

  // Display side: gate the head so nothing stale is shown when empty.
  assign pixel_valid_o = w_valid;
  assign pixel_o       = w_valid ? w_head.pixel     : '0;
  assign line_end_o    = w_valid & w_head.line_end;
  assign frame_end_o   = w_valid & w_head.frame_end;
  assign frame_done_o  = w_done;

endmodule

// File: tb/tb_sram_scanout_reader.sv
// Directed bench for sram_scanout_reader with a 4x2 frame and a 4-deep FIFO.
// A behavioural SRAM returns a word derived from the address one cycle after
// each strobe; strobes and transferred pixels are logged on the falling edge.
module tb_sram_scanout_reader;
  import gpu_scanout_pkg::*;

  localparam int FW = 4;
  localparam int FH = 2;

  logic                  clk;
  logic                  n_rst;
  logic                  enable_i;
  logic                  draw_buffer_i;
  logic [PIXEL_BITS-1:0] sram_rdata;
  logic [ADDR_BITS-1:0]  addr_o;
  logic                  CE0_o, OE_o, R_W_o, CE1_o, LB_o, UB_o, ZZ_o, SEM_o;
  logic [PIXEL_BITS-1:0] pixel_o;
  logic                  pixel_valid_o;
  logic                  pixel_ready_i;
  logic                  line_end_o, frame_end_o, frame_done_o;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  logic [UNDERFLOW_BITS-1:0] underflow_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_BITS-1:0] strobe_q [$];
  pixel_t               pix_q    [$];
  logic [1:0]           flag_q   [$];
  int                   n_done = 0;

  sram_scanout_reader #(
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .enable_i      (enable_i),
    .draw_buffer_i (draw_buffer_i),
    .sram_rdata_i  (sram_rdata),
    .addr_o        (addr_o),
    .CE0_o         (CE0_o),
    .OE_o          (OE_o),
    .R_W_o         (R_W_o),
    .CE1_o         (CE1_o),
    .LB_o          (LB_o),
    .UB_o          (UB_o),
    .ZZ_o          (ZZ_o),
    .SEM_o         (SEM_o),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .pixel_ready_i (pixel_ready_i),
    .line_end_o    (line_end_o),
    .frame_end_o   (frame_end_o),
    .frame_done_o  (frame_done_o)
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt_o (underflow_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pixel_t sram_word(input logic [ADDR_BITS-1:0] a);
    return ~pixel_t'(a);
  endfunction

  function automatic logic [ADDR_BITS-1:0] exp_addr(input logic b, input int y, input int x);
    return {b, HEIGHT_BITS'(y), WIDTH_BITS'(x)};
  endfunction

  // Behavioural SRAM: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (!CE0_o && !OE_o) sram_rdata <= sram_word(addr_o);
  end

  // Log strobes, transfers and done pulses mid-cycle.
  always @(negedge clk) begin
    if (!CE0_o && !OE_o) strobe_q.push_back(addr_o);
    if (pixel_valid_o && pixel_ready_i) begin
      pix_q.push_back(pixel_o);
      flag_q.push_back({line_end_o, frame_end_o});
    end
    if (frame_done_o) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int budget = 200;
    while (strobe_q.size() < n && budget > 0) begin
      step(1);
      budget--;
    end
    check({tag, "_wait_strobes"}, 32'(strobe_q.size() >= n), 32'd1);
  endtask

  task automatic wait_pixels(input int n, input string tag);
    int budget = 200;
    while (pix_q.size() < n && budget > 0) begin
      step(1);
      budget--;
    end
    check({tag, "_wait_pixels"}, 32'(pix_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int budget = 200;
    while (n_done < n && budget > 0) begin
      step(1);
      budget--;
    end
    check({tag, "_wait_done"}, 32'(n_done), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce0"},   32'(CE0_o), 32'd1);
    check({tag, "_oe"},    32'(OE_o), 32'd1);
    check({tag, "_addr"},  32'(addr_o), 32'd0);
    check({tag, "_valid"}, 32'(pixel_valid_o), 32'd0);
    check({tag, "_pixel"}, 32'(pixel_o), 32'd0);
    check({tag, "_flags"}, 32'({line_end_o, frame_end_o, frame_done_o}), 32'd0);
    check({tag, "_static"}, 32'({R_W_o, CE1_o, LB_o, UB_o, ZZ_o, SEM_o}), 32'b110011);
  endtask

  // One full frame from buffer b: strobe addresses, pixel data and flags.
  task automatic check_frame(input int sb, input int pb, input logic b, input string tag);
    logic [ADDR_BITS-1:0] a;
    check({tag, "_nstrobes"}, 32'(strobe_q.size() >= sb + FW * FH), 32'd1);
    check({tag, "_npixels"},  32'(pix_q.size() >= pb + FW * FH), 32'd1);
    for (int i = 0; i < FW * FH; i++) begin
      a = exp_addr(b, i / FW, i % FW);
      if (sb + i < strobe_q.size())
        check($sformatf("%s_addr%0d", tag, i), 32'(strobe_q[sb + i]), 32'(a));
      if (pb + i < pix_q.size()) begin
        check($sformatf("%s_pix%0d", tag, i), 32'(pix_q[pb + i]), 32'(sram_word(a)));
        check($sformatf("%s_flags%0d", tag, i), 32'(flag_q[pb + i]),
              32'({(i % FW) == FW - 1, i == FW * FH - 1}));
      end
    end
  endtask

  initial begin
    int sb, pb, db;
    n_rst         = 1'b0;
    enable_i      = 1'b0;
    draw_buffer_i = 1'b0;
    pixel_ready_i = 1'b0;
    step(3);
    check_reset_outputs("reset");
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    check("reset_underflow", 32'(underflow_cnt_o), 32'd0);
`endif
    n_rst = 1'b1;
    step(2);

    // Basic frame, display always ready; drop enable late so one frame runs.
    sb = strobe_q.size(); pb = pix_q.size(); db = n_done;
    pixel_ready_i = 1'b1;
    enable_i      = 1'b1;
    wait_strobes(sb + 8, "basic");
    enable_i = 1'b0;
    wait_done(db + 1, "basic");
    step(10);
    check("basic_strobe_total", 32'(strobe_q.size() - sb), 32'd8);
    check("basic_pixel_total",  32'(pix_q.size() - pb), 32'd8);
    check("basic_done_once",    32'(n_done - db), 32'd1);
    check("basic_idle_ce0",     32'(CE0_o), 32'd1);
    check_frame(sb, pb, 1'b1, "basic");

    // Display stalled: only FIFO_DEPTH strobes, head pixel held.
    sb = strobe_q.size(); pb = pix_q.size(); db = n_done;
    pixel_ready_i = 1'b0;
    enable_i      = 1'b1;
    step(20);
    check("stall_strobes", 32'(strobe_q.size() - sb), 32'd4);
    check("stall_ce0",     32'(CE0_o), 32'd1);
    check("stall_valid",   32'(pixel_valid_o), 32'd1);
    check("stall_pixel",   32'(pixel_o), 32'(sram_word(exp_addr(1'b1, 0, 0))));
    step(3);
    check("stall_pixel_hold", 32'(pixel_o), 32'(sram_word(exp_addr(1'b1, 0, 0))));
    enable_i      = 1'b0;
    pixel_ready_i = 1'b1;
    wait_done(db + 1, "stall");
    step(5);
    check("stall_strobe_total", 32'(strobe_q.size() - sb), 32'd8);
    check_frame(sb, pb, 1'b1, "stall");

    // Draw buffer flips mid-frame: takes effect only on the next frame.
    sb = strobe_q.size(); pb = pix_q.size(); db = n_done;
    draw_buffer_i = 1'b0;
    enable_i      = 1'b1;
    wait_pixels(pb + 3, "swap");
    draw_buffer_i = 1'b1;
    wait_strobes(sb + 16, "swap");
    enable_i = 1'b0;
    wait_done(db + 2, "swap");
    step(5);
    check_frame(sb, pb, 1'b1, "swap0");
    check_frame(sb + 8, pb + 8, 1'b0, "swap1");
    draw_buffer_i = 1'b0;

    // Reset mid-frame, then a clean frame from (0,0).
    sb = strobe_q.size();
    enable_i = 1'b1;
    wait_strobes(sb + 5, "rst");
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    sb = strobe_q.size(); pb = pix_q.size(); db = n_done;
    n_rst = 1'b1;
    wait_strobes(sb + 8, "rst");
    enable_i = 1'b0;
    wait_done(db + 1, "rst");
    step(5);
    check("rst_first_addr", 32'(strobe_q[sb]), 32'(exp_addr(1'b1, 0, 0)));
    check_frame(sb, pb, 1'b1, "rst");

    // Enable dropped early: frame still completes, then nothing more.
    sb = strobe_q.size(); pb = pix_q.size(); db = n_done;
    enable_i = 1'b1;
    wait_pixels(pb + 2, "drop");
    enable_i = 1'b0;
    wait_done(db + 1, "drop");
    step(20);
    check("drop_strobe_total", 32'(strobe_q.size() - sb), 32'd8);
    check("drop_pixel_total",  32'(pix_q.size() - pb), 32'd8);
    check("drop_done_once",    32'(n_done - db), 32'd1);
    check("drop_idle_valid",   32'(pixel_valid_o), 32'd0);
    check_frame(sb, pb, 1'b1, "drop");

`ifdef SCANOUT_UNDERFLOW_CNT_EN
    // Ready high through the two-cycle fill gap and the final done cycle.
    db = n_done;
    sb = strobe_q.size();
    enable_i = 1'b1;
    wait_strobes(sb + 1, "uflow");
    enable_i = 1'b0;
    wait_done(db + 1, "uflow");
    step(3);
    check("uflow_count", 32'(underflow_cnt_o), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
